// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared definitions for the accumulator command sequencer.
//   - ALU opcode encodings (OP_*)
//   - sequencer state type (state_e)
//   - width of the completed-transaction counter (OP_CNT_W)
package alu_ctrl_pkg;

  localparam logic [2:0] OP_NOP0 = 3'b000;
  localparam logic [2:0] OP_NOP1 = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_NOP6 = 3'b110;
  localparam logic [2:0] OP_NOP7 = 3'b111;

  localparam int unsigned OP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/alu_ctrl.sv
// alu_ctrl: accumulator-style command sequencer driving an external combinational ALU.
//
// One command per transaction: IDLE accepts (cmd_op, cmd_data), EXEC lets the ALU
// combine acc with the latched operand and writes alu_out back into acc, RESP
// presents the new accumulator until the consumer takes it.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   cmd_valid/ready   command handshake; cmd_op = ALU opcode, cmd_data = operand B
//   alu_opcode        latched opcode to the ALU
//   alu_in_a          accumulator to the ALU
//   alu_in_b          latched operand to the ALU
//   alu_out           ALU result
//   alu_a_is_zero     ALU flag: alu_in_a == 0
//   rsp_valid/ready   response handshake; rsp_data = accumulator, rsp_zero = acc is zero
//   rsp_carry         carry out of the last ADD (only with ALU_CTRL_CARRY_EN)
//   op_cnt            completed transactions, wraps at 2^16
//
// Build option: define ALU_CTRL_CARRY_EN to add the carry register and rsp_carry port.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [WIDTH-1:0]    cmd_data,
  output logic [2:0]          alu_opcode,
  output logic [WIDTH-1:0]    alu_in_a,
  output logic [WIDTH-1:0]    alu_in_b,
  input  logic [WIDTH-1:0]    alu_out,
  input  logic                alu_a_is_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_zero,
`ifdef ALU_CTRL_CARRY_EN
  output logic                rsp_carry,
`endif
  output logic [OP_CNT_W-1:0] op_cnt
);

  state_e                state_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic [WIDTH-1:0]      acc_q;
  logic [2:0]            op_q;
  logic [WIDTH-1:0]      opnd_q;
  logic [OP_CNT_W-1:0]   op_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      acc_q       <= '0;
      op_q        <= OP_NOP0;
      opnd_q      <= '0;
      op_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q        <= cmd_op;
            opnd_q      <= cmd_data;
            cmd_ready_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          acc_q       <= alu_out;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            op_cnt_q    <= op_cnt_q + 1'b1;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_CTRL_CARRY_EN
  logic add_carry;
  logic carry_q;

  // Private widened adder: the external ALU does not export its carry.
  assign add_carry = |(({1'b0, acc_q} + {1'b0, opnd_q}) >> WIDTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (state_q == EXEC) begin
      carry_q <= (op_q == OP_ADD) ? add_carry : 1'b0;
    end
  end

  assign rsp_carry = carry_q;
`endif

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign alu_opcode = op_q;
  assign alu_in_a   = acc_q;
  assign alu_in_b   = opnd_q;
  assign rsp_data   = acc_q;
  // alu_in_a is the accumulator, so the ALU's zero flag describes rsp_data.
  assign rsp_zero   = alu_a_is_zero;
  assign op_cnt     = op_cnt_q;

endmodule
